// File: rtl/multi_wave_display_pkg.sv
// Shared types and screen constants for the multi-channel trace pixel generator.
package multi_wave_display_pkg;

  typedef enum logic [1:0] {
    LIVE          = 2'd0,
    FREEZE_PEND   = 2'd1,
    FROZEN        = 2'd2,
    UNFREEZE_PEND = 2'd3
  } frz_state_e;

  localparam int SCREEN_W  = 1280;
  localparam int SCREEN_H  = 1024;
  localparam int X_MIN_DEF = 31;
  localparam int X_MAX_DEF = 1238;
  localparam int CH_IDX_W  = 3;
  localparam int X_W       = $clog2(SCREEN_W);
  localparam int Y_W       = $clog2(SCREEN_H);
  localparam int ADDR_W    = 10;
  localparam int COL_W     = ADDR_W - 1;

endpackage

// File: rtl/multi_wave_display_seg.sv
// Per-channel stage-1 segment comparator: holds the previous column's sample and
// reports whether the current row lies on the segment joining it to this column.
module wave_seg_hit
  import multi_wave_display_pkg::*;
#(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                col_chg_i,
  input  logic                line_start_i,
  input  logic [SAMPLE_W-1:0] cur_i,
  input  logic [SAMPLE_W-1:0] row_i,
  output logic                hit_o
);

  logic [SAMPLE_W-1:0] prev_q, last_q;
  logic [SAMPLE_W-1:0] prev_eff, lo, hi;

  // On a column change the register update lands next cycle, so bypass last_q now.
  always_comb begin
    prev_eff = col_chg_i ? last_q : prev_q;
    if (line_start_i) prev_eff = cur_i;
    lo    = (cur_i < prev_eff) ? cur_i : prev_eff;
    hi    = (cur_i < prev_eff) ? prev_eff : cur_i;
    hit_o = (row_i >= lo) && (row_i <= hi);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      last_q <= '0;
    end else begin
      last_q <= cur_i;
      if (col_chg_i) prev_q <= last_q;
    end
  end

endmodule

// File: rtl/multi_wave_display.sv
// Multi-channel scope trace pixel generator; fixed 2 clk x/y -> outputs, no backpressure.
// Grid overlay is built only when MULTI_WAVE_DISPLAY_GRID_EN is defined.
module multi_wave_display
  import multi_wave_display_pkg::*;
#(
  parameter int SAMPLE_W  = 8,
  parameter int NUM_CH    = 2,
  parameter int COL_SHIFT = 1,
  parameter int Y_SHIFT   = 1,
  parameter int X_MIN     = X_MIN_DEF,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int INVERT_Y  = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [X_W-1:0]             x_i,
  input  logic [Y_W-1:0]             y_i,
  input  logic                       read_index_i,
  input  logic                       freeze_req_i,
  input  logic [NUM_CH-1:0]          ch_enable_i,
  output logic [ADDR_W-1:0]          read_address_o,
  input  logic [NUM_CH*SAMPLE_W-1:0] read_value_i,
  output logic                       display_wave_o,
  output logic [CH_IDX_W-1:0]        wave_ch_o,
  output logic                       frozen_o,
  output logic                       display_grid_o
);

  frz_state_e state_q;
  logic       held_bank_q, frozen_q;
  logic       frame_start, eff_bank, win_d;
  logic [COL_W-1:0] col0;

  assign frame_start    = (x_i == '0) && (y_i == '0);
  assign eff_bank       = (state_q == FROZEN || state_q == UNFREEZE_PEND) ? held_bank_q : read_index_i;
  assign col0           = COL_W'(x_i >> COL_SHIFT);
  assign read_address_o = {eff_bank, col0};
  assign win_d          = (int'(x_i) >= X_MIN) && (int'(x_i) <= X_MAX);

  // Bank switches only at frame start so a frozen frame is never torn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LIVE;
      held_bank_q <= 1'b0;
      frozen_q    <= 1'b0;
    end else begin
      case (state_q)
        LIVE: if (freeze_req_i) state_q <= FREEZE_PEND;
        FREEZE_PEND: begin
          if (!freeze_req_i) begin
            state_q <= LIVE;
          end else if (frame_start) begin
            state_q     <= FROZEN;
            held_bank_q <= read_index_i;
            frozen_q    <= 1'b1;
          end
        end
        FROZEN: if (!freeze_req_i) state_q <= UNFREEZE_PEND;
        UNFREEZE_PEND: begin
          if (freeze_req_i) begin
            state_q <= FROZEN;
          end else if (frame_start) begin
            state_q  <= LIVE;
            frozen_q <= 1'b0;
          end
        end
        default: state_q <= LIVE;
      endcase
    end
  end

  logic [COL_W-1:0]  col1_q, colp_q;
  logic [Y_W-1:0]    y1_q;
  logic              win1_q;
  logic [NUM_CH-1:0] en1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col1_q <= '0;
      colp_q <= '0;
      y1_q   <= '0;
      win1_q <= 1'b0;
      en1_q  <= '0;
    end else begin
      col1_q <= col0;
      colp_q <= col1_q;
      y1_q   <= y_i;
      win1_q <= win_d;
      en1_q  <= ch_enable_i;
    end
  end

  logic [31:0]         y_ext;
  logic                row_ok;
  logic [SAMPLE_W-1:0] row_raw, row;

  assign y_ext   = 32'(y1_q);
  assign row_ok  = (y_ext >> (SAMPLE_W + Y_SHIFT)) == 32'd0;
  assign row_raw = SAMPLE_W'(y_ext >> Y_SHIFT);
  assign row     = (INVERT_Y != 0) ? ~row_raw : row_raw;

  logic [NUM_CH-1:0] hit, sel;
  logic              col_chg, line_start;

  assign col_chg    = col1_q != colp_q;
  assign line_start = col1_q == '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wave_seg_hit #(.SAMPLE_W(SAMPLE_W)) u_seg (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .col_chg_i    (col_chg),
      .line_start_i (line_start),
      .cur_i        (read_value_i[c*SAMPLE_W +: SAMPLE_W]),
      .row_i        (row),
      .hit_o        (hit[c])
    );
  end

  assign sel = hit & en1_q;

  logic                wave_d, wave_q;
  logic [CH_IDX_W-1:0] ch_d, ch_q;

  always_comb begin
    wave_d = win1_q && row_ok && (|sel);
    ch_d   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (sel[c]) ch_d = CH_IDX_W'(c);
    end
    if (!wave_d) ch_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wave_q <= 1'b0;
      ch_q   <= '0;
    end else begin
      wave_q <= wave_d;
      ch_q   <= ch_d;
    end
  end

  assign display_wave_o = wave_q;
  assign wave_ch_o      = ch_q;
  assign frozen_o       = frozen_q;

`ifdef MULTI_WAVE_DISPLAY_GRID_EN
  logic [X_W-1:0] x1_q;
  logic           grid_d, grid_q;

  assign grid_d = win1_q && !wave_d && ((x1_q[5:0] == 6'd0) || (row[4:0] == 5'd0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x1_q   <= '0;
      grid_q <= 1'b0;
    end else begin
      x1_q   <= x_i;
      grid_q <= grid_d;
    end
  end

  assign display_grid_o = grid_q;
`else
  assign display_grid_o = 1'b0;
`endif

endmodule
